axi_lite_slave_regs: RTL

//  AXI4-Lite responder (slave) for the AXI_master initiator: NUM_REGS x 32-bit register file.

---
 rtl/axi_lite_slave_regs_pkg.sv | 18 +
 rtl/axi_lite_defs.vh | 17 +
 rtl/axil_slv_regfile.sv | 40 ++++
 rtl/axi_lite_slave_regs.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/axi_lite_slave_regs_pkg.sv
// rtl/axi_lite_slave_regs_pkg.sv - state types shared by the AXI4-Lite register responder
`include "axi_lite_defs.vh"

package axi_lite_slave_regs_pkg;

    typedef enum logic [1:0] {
        WR_IDLE    = `AXIL_WR_IDLE,
        WR_HAVE_AW = `AXIL_WR_HAVE_AW,
        WR_HAVE_W  = `AXIL_WR_HAVE_W,
        WR_RESP    = `AXIL_WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = `AXIL_RD_IDLE,
        RD_DATA = `AXIL_RD_DATA
    } rd_state_t;

endpackage

// File: rtl/axi_lite_defs.vh
// rtl/axi_lite_defs.vh - AXI4-Lite response codes and responder FSM state encodings
`ifndef AXI_LITE_DEFS_VH
`define AXI_LITE_DEFS_VH

`define AXI_RESP_OKAY    2'b00
`define AXI_RESP_SLVERR  2'b10
`define AXI_RESP_DECERR  2'b11

`define AXIL_WR_IDLE     2'd0
`define AXIL_WR_HAVE_AW  2'd1
`define AXIL_WR_HAVE_W   2'd2
`define AXIL_WR_RESP     2'd3

`define AXIL_RD_IDLE     1'b0
`define AXIL_RD_DATA     1'b1

`endif

// File: rtl/axil_slv_regfile.sv
// rtl/axil_slv_regfile.sv - NUM_REGS x 32 register storage, byte-strobed write, registered read
// Ports: ACLK/ARESETn clock and async active-low reset; wr_en/wr_idx/wr_data/wr_strb write port;
//        rd_en/rd_idx load rd_data from storage, rd_clr forces rd_data to zero.
module axil_slv_regfile #(
    parameter int          NUM_REGS  = 16,
    parameter int          IDX_W     = 4,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_strb,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic             rd_clr,
    output logic [31:0]      rd_data
);

    logic [31:0] regs [NUM_REGS];

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= RESET_VAL;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Reads sample storage before any same-edge write lands, so a colliding read sees the old value.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)    rd_data <= '0;
        else if (rd_en)  rd_data <= regs[rd_idx];
        else if (rd_clr) rd_data <= '0;
    end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// rtl/axi_lite_slave_regs.sv - AXI4-Lite responder fronting a NUM_REGS x 32-bit register file
// Ports: ACLK, ARESETn (async, active-low); AW/W/B write channels; AR/R read channels.
// Build option AXIL_SLV_DECERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
`include "axi_lite_defs.vh"

module axi_lite_slave_regs
    import axi_lite_slave_regs_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 32,
    parameter int          NUM_REGS  = 16,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic                WVALID,
    output logic                WREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    output logic                BVALID,
    input  logic                BREADY,
    output logic [1:0]          BRESP,
    input  logic                ARVALID,
    output logic                ARREADY,
    input  logic [ADDR_W-1:0]   ARADDR,
    output logic                RVALID,
    input  logic                RREADY,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP
);

    localparam int              IDX_W      = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_REGS * 4);
`ifdef AXIL_SLV_DECERR_EN
    localparam logic [1:0]      MISS_RESP  = `AXI_RESP_SLVERR;
`else
    localparam logic [1:0]      MISS_RESP  = `AXI_RESP_OKAY;
`endif

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;

    logic [ADDR_W-1:0] aw_addr_q;
    logic [31:0]       w_data_q;
    logic [3:0]        w_strb_q;

    logic aw_hs, w_hs, ar_hs, r_hs, commit;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;
    logic              wr_in_range, ar_in_range;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign ar_hs = ARVALID && ARREADY;
    assign r_hs  = RVALID && RREADY;

    // Whichever half arrives second is taken straight from the bus; the first was latched.
    assign wr_addr     = (wr_state == WR_HAVE_AW) ? aw_addr_q : AWADDR;
    assign wr_data     = (wr_state == WR_HAVE_W)  ? w_data_q  : WDATA;
    assign wr_strb     = (wr_state == WR_HAVE_W)  ? w_strb_q  : WSTRB;
    assign wr_in_range = wr_addr < ADDR_LIMIT;
    assign ar_in_range = ARADDR < ADDR_LIMIT;

    always_comb begin
        wr_next = wr_state;
        commit  = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_next = WR_RESP;
                    commit  = 1'b1;
                end else if (aw_hs) begin
                    wr_next = WR_HAVE_AW;
                end else if (w_hs) begin
                    wr_next = WR_HAVE_W;
                end
            end
            WR_HAVE_AW: if (w_hs) begin
                wr_next = WR_RESP;
                commit  = 1'b1;
            end
            WR_HAVE_W: if (aw_hs) begin
                wr_next = WR_RESP;
                commit  = 1'b1;
            end
            WR_RESP: if (BVALID && BREADY) wr_next = WR_IDLE;
            default: wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_hs) rd_next = RD_DATA;
            RD_DATA: if (r_hs)  rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they are all 0 while in reset
    // and first rise on the edge after release.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_state  <= WR_IDLE;
            rd_state  <= RD_IDLE;
            AWREADY   <= 1'b0;
            WREADY    <= 1'b0;
            BVALID    <= 1'b0;
            BRESP     <= `AXI_RESP_OKAY;
            ARREADY   <= 1'b0;
            RVALID    <= 1'b0;
            RRESP     <= `AXI_RESP_OKAY;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
            AWREADY  <= (wr_next == WR_IDLE) || (wr_next == WR_HAVE_W);
            WREADY   <= (wr_next == WR_IDLE) || (wr_next == WR_HAVE_AW);
            BVALID   <= (wr_next == WR_RESP);
            ARREADY  <= (rd_next == RD_IDLE);
            RVALID   <= (rd_next == RD_DATA);
            if (aw_hs)  aw_addr_q <= AWADDR;
            if (w_hs) begin
                w_data_q <= WDATA;
                w_strb_q <= WSTRB;
            end
            if (commit) BRESP <= wr_in_range ? `AXI_RESP_OKAY : MISS_RESP;
            if (ar_hs)  RRESP <= ar_in_range ? `AXI_RESP_OKAY : MISS_RESP;
        end
    end

    axil_slv_regfile #(
        .NUM_REGS  (NUM_REGS),
        .IDX_W     (IDX_W),
        .RESET_VAL (RESET_VAL)
    ) u_regfile (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .wr_en   (commit && wr_in_range),
        .wr_idx  (wr_addr[IDX_W+1:2]),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .rd_en   (ar_hs && ar_in_range),
        .rd_idx  (ARADDR[IDX_W+1:2]),
        .rd_clr  (r_hs || (ar_hs && !ar_in_range)),
        .rd_data (RDATA)
    );

endmodule
